// File: rtl/display_bus_arbiter.sv
// Round-robin arbiter that serialises NREQ simple req/ack ports onto one AXI4-Lite master
// port driving the seven-segment display slave (AW, then W, then B; or AR, then R).
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for any req; picks next requester after rr_ptr
// S_AW   | AWVALID held with latched address until AWREADY
// S_W    | WVALID held with latched data, full strobes, until WREADY
// S_B    | BREADY high until BVALID; BRESP captured
// S_AR   | ARVALID held with latched address until ARREADY
// S_R    | RREADY high until RVALID; RDATA/RRESP captured
// S_ACK  | one-cycle ack pulse to the granted requester
module display_bus_arbiter #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 32
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*32-1:0]     req_wdata,
    output logic [NREQ-1:0]        ack,
    output logic [31:0]            rsp_rdata,
    output logic [1:0]             rsp_resp,
    output logic [ADDR_W-1:0]      AWADDR,
    output logic                   AWVALID,
    output logic                   AWPROT,
    input  logic                   AWREADY,
    output logic [31:0]            WDATA,
    output logic [3:0]             WSTRB,
    output logic                   WVALID,
    input  logic                   WREADY,
    output logic                   BREADY,
    input  logic                   BVALID,
    input  logic [1:0]             BRESP,
    output logic [ADDR_W-1:0]      ARADDR,
    output logic                   ARVALID,
    output logic                   ARPROT,
    input  logic                   ARREADY,
    output logic                   RREADY,
    input  logic                   RVALID,
    input  logic [31:0]            RDATA,
    input  logic [1:0]             RRESP
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R,
        S_ACK
    } state_t;

    state_t              state_q;
    logic [IW-1:0]       rr_q;
    logic [IW-1:0]       gnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic                awvalid_q;
    logic                wvalid_q;
    logic                bready_q;
    logic                arvalid_q;
    logic                rready_q;
    logic [NREQ-1:0]     ack_q;
    logic [31:0]         rdata_q;
    logic [1:0]          resp_q;

    logic [IW-1:0]       pick_d;
    logic                found_d;

    // Search starts one past the last grant, so the last winner has lowest priority.
    always_comb begin
        pick_d  = rr_q;
        found_d = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found_d && req[(int'(rr_q) + k) % NREQ]) begin
                found_d = 1'b1;
                pick_d  = IW'((int'(rr_q) + k) % NREQ);
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q   <= S_IDLE;
            rr_q      <= IW'(NREQ - 1);
            gnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (found_d) begin
                        gnt_q   <= pick_d;
                        rr_q    <= pick_d;
                        addr_q  <= req_addr[int'(pick_d)*ADDR_W +: ADDR_W];
                        wdata_q <= req_wdata[int'(pick_d)*32 +: 32];
                        if (req_we[pick_d]) begin
                            awvalid_q <= 1'b1;
                            state_q   <= S_AW;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_AR;
                        end
                    end
                end
                S_AW: begin
                    if (AWREADY) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        state_q   <= S_W;
                    end
                end
                S_W: begin
                    if (WREADY) begin
                        wvalid_q <= 1'b0;
                        bready_q <= 1'b1;
                        state_q  <= S_B;
                    end
                end
                S_B: begin
                    if (BVALID) begin
                        bready_q      <= 1'b0;
                        resp_q        <= BRESP;
                        rdata_q       <= '0;
                        ack_q[gnt_q]  <= 1'b1;
                        state_q       <= S_ACK;
                    end
                end
                S_AR: begin
                    if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_R;
                    end
                end
                S_R: begin
                    if (RVALID) begin
                        rready_q      <= 1'b0;
                        rdata_q       <= RDATA;
                        resp_q        <= RRESP;
                        ack_q[gnt_q]  <= 1'b1;
                        state_q       <= S_ACK;
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack       = ack_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;
    assign AWADDR    = addr_q;
    assign AWVALID   = awvalid_q;
    assign AWPROT    = 1'b0;
    assign WDATA     = wdata_q;
    assign WSTRB     = 4'hF;
    assign WVALID    = wvalid_q;
    assign BREADY    = bready_q;
    assign ARADDR    = addr_q;
    assign ARVALID   = arvalid_q;
    assign ARPROT    = 1'b0;
    assign RREADY    = rready_q;

endmodule

// File: tb/tb_display_bus_arbiter.sv
// Bench for display_bus_arbiter: behavioural display slave plus directed requests, with
// expected acks queued at issue time and checked by an independent ack monitor.
module tb_display_bus_arbiter;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 32;

    logic                   ACLK = 1'b0;
    logic                   ARESETn;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*32-1:0]     req_wdata;
    logic [NREQ-1:0]        ack;
    logic [31:0]            rsp_rdata;
    logic [1:0]             rsp_resp;
    logic [ADDR_W-1:0]      AWADDR, ARADDR;
    logic                   AWVALID, AWPROT, AWREADY, WVALID, WREADY, BREADY, BVALID;
    logic                   ARVALID, ARPROT, ARREADY, RREADY, RVALID;
    logic [31:0]            WDATA, RDATA;
    logic [3:0]             WSTRB;
    logic [1:0]             BRESP, RRESP;

    always #5 ACLK = ~ACLK;

    display_bus_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .ack(ack), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWPROT(AWPROT), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BREADY(BREADY), .BVALID(BVALID), .BRESP(BRESP),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARPROT(ARPROT), .ARREADY(ARREADY),
        .RREADY(RREADY), .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Display slave: one-cycle registered READY per channel, optional AW stall.
    int          sl_st;
    int          aw_cnt;
    int          aw_stall  = 1;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [31:0] disp_reg;

    always @(posedge ACLK) begin
        if (!ARESETn) begin
            AWREADY <= 1'b0; WREADY <= 1'b0; BVALID <= 1'b0; BRESP <= 2'b00;
            ARREADY <= 1'b0; RVALID <= 1'b0; RDATA <= 32'h0; RRESP <= 2'b00;
            disp_reg <= 32'h0; aw_cnt <= 0; sl_st <= 0;
        end else begin
            case (sl_st)
                0: begin
                    if (AWVALID && AWREADY) begin
                        AWREADY <= 1'b0; WREADY <= 1'b1; aw_cnt <= 0; sl_st <= 1;
                    end else if (AWVALID) begin
                        if (aw_cnt + 1 >= aw_stall) AWREADY <= 1'b1;
                        else aw_cnt <= aw_cnt + 1;
                    end else if (ARVALID && ARREADY) begin
                        ARREADY <= 1'b0; RVALID <= 1'b1; RDATA <= disp_reg; RRESP <= 2'b00; sl_st <= 3;
                    end else if (ARVALID) begin
                        ARREADY <= 1'b1;
                    end
                end
                1: if (WVALID && WREADY) begin
                    WREADY <= 1'b0; disp_reg <= WDATA; BVALID <= 1'b1; BRESP <= bresp_cfg; sl_st <= 2;
                end
                2: if (BVALID && BREADY) begin BVALID <= 1'b0; sl_st <= 0; end
                3: if (RVALID && RREADY) begin RVALID <= 1'b0; sl_st <= 0; end
                default: sl_st <= 0;
            endcase
        end
    end

    typedef struct {
        logic [NREQ-1:0] ack;
        logic [31:0]     rdata;
        logic [1:0]      resp;
    } exp_t;

    exp_t            sb_q[$];
    logic [NREQ-1:0] prev_ack = '0;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge ACLK);
            if (prev_ack != '0) check("ack_one_cycle", ack, 0);
            if (ack != '0) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ack", ack, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("ack_gnt", ack, e.ack);
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_resp", rsp_resp, e.resp);
                end
            end
            prev_ack = ack;
        end
    end

    function automatic exp_t mk_exp(input int idx, input logic [31:0] rdata, input logic [1:0] resp);
        exp_t e;
        e.ack      = '0;
        e.ack[idx] = 1'b1;
        e.rdata    = rdata;
        e.resp     = resp;
        return e;
    endfunction

    // Called with the arbiter in IDLE; returns one cycle after ack (arbiter back in IDLE).
    task automatic do_txn(input int idx, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] exp_resp,
                          input logic [31:0] exp_rdata, input int exp_ack_cyc,
                          input int exp_w_cyc, input int drop_at);
        int first_a = -1;
        int first_w = -1;
        bit got     = 1'b0;
        sb_q.push_back(mk_exp(idx, exp_rdata, exp_resp));
        req_we[idx]                    = we;
        req_addr[idx*ADDR_W +: ADDR_W] = addr;
        req_wdata[idx*32 +: 32]        = wdata;
        req[idx]                       = 1'b1;
        for (int c = 1; c <= 60 && !got; c++) begin
            @(negedge ACLK);
            if (c == 1) begin
                req_addr[idx*ADDR_W +: ADDR_W] = ~addr;
                req_wdata[idx*32 +: 32]        = ~wdata;
            end
            if (c == drop_at) req[idx] = 1'b0;
            if (AWVALID) begin
                if (first_a < 0) first_a = c;
                check("awaddr_held", AWADDR, addr);
                check("wvalid_before_aw_hs", WVALID, 0);
            end
            if (ARVALID) begin
                if (first_a < 0) first_a = c;
                check("araddr_held", ARADDR, addr);
            end
            if (WVALID) begin
                if (first_w < 0) first_w = c;
                check("wdata_held", WDATA, wdata);
                check("wstrb", WSTRB, 4'hF);
            end
            if (ack != '0) begin
                got = 1'b1;
                check("ack_latency", c, exp_ack_cyc);
            end
        end
        check("ack_seen", got, 1);
        if (!got) sb_q.delete();
        check("addr_phase_cycle", first_a, 1);
        if (we) check("w_phase_cycle", first_w, exp_w_cyc);
        req[idx] = 1'b0;
        @(negedge ACLK);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        int exp_g[4];
        bit seen_w;
        ARESETn = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge ACLK);
        check("rst_awvalid", AWVALID, 0);
        check("rst_wvalid", WVALID, 0);
        check("rst_bready", BREADY, 0);
        check("rst_arvalid", ARVALID, 0);
        check("rst_rready", RREADY, 0);
        check("rst_ack", ack, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_resp", rsp_resp, 0);
        check("rst_awaddr", AWADDR, 0);
        check("rst_prot", {AWPROT, ARPROT}, 0);
        ARESETn = 1'b1;
        @(negedge ACLK);

        // req0 write then req1 read of the same register
        do_txn(0, 1'b1, 32'h0, 32'h1234_5678, 2'b00, 32'h0, 5, 3, 0);
        check("disp_reg_after_write", disp_reg, 32'h1234_5678);
        do_txn(1, 1'b0, 32'h0, 32'h0, 2'b00, 32'h1234_5678, 4, 0, 0);
        check("rsp_hold_in_idle", rsp_rdata, 32'h1234_5678);
        do_txn(0, 1'b0, 32'h0, 32'h0, 2'b00, 32'h1234_5678, 4, 0, 0);

        // Last grant was 0, so continuous 2'b11 writes alternate 1,0,1,0.
        exp_g = '{1, 0, 1, 0};
        for (int i = 0; i < 4; i++) sb_q.push_back(mk_exp(exp_g[i], 32'h0, 2'b00));
        req_we    = 2'b11;
        req_addr  = {32'h0000_000C, 32'h0000_0008};
        req_wdata = {32'hB1B1_1111, 32'hA0A0_0000};
        req       = 2'b11;
        n = 0;
        for (int c = 1; c <= 200 && n < 4; c++) begin
            @(negedge ACLK);
            if (ack != '0) begin
                check("rr_ack_cycle", c, 5 + 6*n);
                check("rr_disp_reg", disp_reg, (exp_g[n] == 1) ? 32'hB1B1_1111 : 32'hA0A0_0000);
                n++;
                if (n == 4) req = '0;
            end
        end
        check("rr_ack_count", n, 4);
        @(negedge ACLK);

        // AWREADY held off for 10 cycles of AWVALID
        aw_stall = 10;
        do_txn(0, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 2'b00, 32'h0, 14, 12, 0);
        aw_stall = 1;
        check("disp_reg_after_stall", disp_reg, 32'hCAFE_F00D);

        // SLVERR passthrough, requester drops req mid-transaction
        bresp_cfg = 2'b10;
        do_txn(1, 1'b1, 32'h0000_0020, 32'h5555_AAAA, 2'b10, 32'h0, 5, 3, 2);
        bresp_cfg = 2'b00;

        // Reset while in W
        req_we[0] = 1'b1;
        req_addr[0 +: ADDR_W] = 32'h0000_0030;
        req_wdata[0 +: 32] = 32'hDEAD_BEEF;
        req[0] = 1'b1;
        seen_w = 1'b0;
        for (int c = 1; c <= 20 && !seen_w; c++) begin
            @(negedge ACLK);
            if (WVALID) seen_w = 1'b1;
        end
        check("reached_w_state", seen_w, 1);
        ARESETn = 1'b0;
        req = '0;
        @(negedge ACLK);
        check("midrst_awvalid", AWVALID, 0);
        check("midrst_wvalid", WVALID, 0);
        check("midrst_bready", BREADY, 0);
        check("midrst_arvalid", ARVALID, 0);
        check("midrst_rready", RREADY, 0);
        check("midrst_ack", ack, 0);
        check("midrst_resp", rsp_resp, 0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        do_txn(1, 1'b0, 32'h0000_0030, 32'h0, 2'b00, 32'h0, 4, 0, 0);
        do_txn(0, 1'b1, 32'h0000_0004, 32'h0BAD_F00D, 2'b00, 32'h0, 5, 3, 0);
        check("disp_reg_after_reset", disp_reg, 32'h0BAD_F00D);

        repeat (3) @(negedge ACLK);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
